axi_b_resp_buffer: RTL

AXI_B_RESP_BUFFER -- requirements
Module: axi_b_resp_buffer

---
 rtl/axi_reg_slice_pkg.sv | 14 +
 rtl/axi_sat_counter.sv | 34 +++
 rtl/axi_b_resp_buffer.sv | 100 ++++++++++
 3 files changed

// File: rtl/axi_reg_slice_pkg.sv
// Shared AXI response encodings and error-statistics counter width.
// Used by axi_b_resp_buffer and its optional error counters.
package axi_reg_slice_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int ERR_CNT_WIDTH = 16;

endpackage

// File: rtl/axi_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over an increment.
module axi_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/axi_b_resp_buffer.sv
// DEPTH-entry FIFO on the AXI write-response (B) channel, one cycle of latency, full throughput.
// Optional SLVERR/DECERR statistics are compiled in when AXI_B_ERR_STATS_EN is defined.
module axi_b_resp_buffer
    import axi_reg_slice_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       bvalidm,
    output logic                       breadym,
    input  logic [ID_WIDTH-1:0]        bidm,
    input  logic [1:0]                 brespm,
    input  logic [USER_WIDTH-1:0]      buserm,
    output logic                       bvalids,
    input  logic                       breadys,
    output logic [ID_WIDTH-1:0]        bids,
    output logic [1:0]                 bresps,
    output logic [USER_WIDTH-1:0]      busers,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef AXI_B_ERR_STATS_EN
    ,
    input  logic                       err_clr,
    output logic [ERR_CNT_WIDTH-1:0]   slverr_cnt,
    output logic [ERR_CNT_WIDTH-1:0]   decerr_cnt
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = ID_WIDTH + 2 + USER_WIDTH;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               push;
    logic               pop;

    // Handshake outputs come from the occupancy register; areset masks them so
    // no beat is accepted or delivered in a cycle whose contents are discarded.
    assign breadym = (occ_q != OCC_W'(DEPTH)) && !areset;
    assign bvalids = (occ_q != '0) && !areset;

    assign push = bvalidm && breadym;
    assign pop  = bvalids && breadys;

    assign {bids, bresps, busers} = mem_q[rd_ptr_q];
    assign occupancy              = occ_q;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bidm, brespm, buserm};
        end
    end

`ifdef AXI_B_ERR_STATS_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt [2];

    // Index 0 counts SLVERR, index 1 counts DECERR.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_err_cnt
        localparam logic [1:0] CODE = (gi == 0) ? RESP_SLVERR : RESP_DECERR;

        axi_sat_counter #(
            .WIDTH (ERR_CNT_WIDTH)
        ) u_cnt (
            .aclk   (aclk),
            .areset (areset),
            .clr    (err_clr),
            .inc    (push && (brespm == CODE)),
            .count  (err_cnt[gi])
        );
    end

    assign slverr_cnt = err_cnt[0];
    assign decerr_cnt = err_cnt[1];
`endif

endmodule
